// File: rtl/rhythm_pkg.sv
// Shared types and sizes for the rhythm-game beatmap player.
package rhythm_pkg;
    localparam int LANES      = 8;
    localparam int ROW_ADDR_W = 3;
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT,
        WAIT_BEAT,
        DONE
    } player_state_e;

    function automatic logic is_playing(input player_state_e s);
        return (s == FETCH) || (s == EMIT) || (s == WAIT_BEAT);
    endfunction
endpackage

// File: rtl/beat_timer.sv
// Beat down-counter: ticks on the enabled cycle where the count is zero, then reloads.
module beat_timer #(
    parameter int BEAT_CYCLES = 25000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic reload,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] TOP = CW'(BEAT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick    = enable && (count_q == '0);
        count_d = count_q;
        if (reload || tick) begin
            count_d = TOP;
        end else if (enable) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/beatmap_player.sv
// Steps through an external 8-row beatmap ROM, offering each non-empty row to the renderer once per beat.
module beatmap_player
    import rhythm_pkg::*;
#(
    parameter int BEAT_CYCLES = 25000000,
    parameter bit LOOP        = 1'b0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  pause,
    output logic [ROW_ADDR_W-1:0] beat_addr,
    input  logic [LANES-1:0]      beat_notes,
    output logic                  spawn_valid,
    output logic [LANES-1:0]      spawn_lanes,
    input  logic                  spawn_ready,
    output logic                  playing,
    output logic                  done,
    output logic                  overrun
);
    player_state_e         state_q, state_d;
    logic [ROW_ADDR_W-1:0] addr_q, addr_d;
    logic [LANES-1:0]      lanes_q, lanes_d;
    logic                  valid_q, valid_d;
    logic                  playing_q, playing_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    logic                  tick, reload, timer_en, handshake;
    player_state_e         advance_state;
    logic [ROW_ADDR_W-1:0] advance_addr;

    assign reload    = start && ((state_q == IDLE) || (state_q == DONE));
    assign timer_en  = is_playing(state_q) && !pause;
    assign handshake = valid_q && spawn_ready;

    beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
        .clock  (clock),
        .resetn (resetn),
        .reload (reload),
        .enable (timer_en),
        .tick   (tick)
    );

    // Where a beat boundary leads: the last row either ends playback or wraps.
    always_comb begin
        advance_state = FETCH;
        advance_addr  = addr_q + ROW_ADDR_W'(1);
        if ((addr_q == LAST_ROW) && !LOOP) begin
            advance_state = DONE;
            advance_addr  = addr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lanes_d   = lanes_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    addr_d    = '0;
                    overrun_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                lanes_d = beat_notes;
                state_d = (beat_notes != '0) ? EMIT : WAIT_BEAT;
            end
            EMIT: begin
                if (tick) begin
                    // A row still unaccepted at the beat boundary is dropped.
                    if (!handshake) overrun_d = 1'b1;
                    addr_d  = advance_addr;
                    state_d = advance_state;
                end else if (handshake) begin
                    state_d = WAIT_BEAT;
                end
            end
            WAIT_BEAT: begin
                if (tick) begin
                    addr_d  = advance_addr;
                    state_d = advance_state;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d   = (state_d == EMIT);
        playing_d = is_playing(state_d);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lanes_q   <= '0;
            valid_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lanes_q   <= lanes_d;
            valid_q   <= valid_d;
            playing_q <= playing_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign beat_addr   = addr_q;
    assign spawn_lanes = lanes_q;
    assign spawn_valid = valid_q;
    assign playing     = playing_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_beatmap_player.sv
// Bench for beatmap_player: one-shot and looping instances checked edge by edge against a beat-timeline model.
module tb_beatmap_player;
    localparam int BC = 4;
    localparam int N  = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn, start, pause, spawn_ready;
    logic [7:0] rom [8];

    logic [1:0][2:0] got_addr;
    logic [1:0][7:0] got_notes, got_lanes;
    logic [1:0]      got_valid, got_play, got_done, got_over;

    assign got_notes[0] = rom[got_addr[0]];
    assign got_notes[1] = rom[got_addr[1]];

    beatmap_player #(.BEAT_CYCLES(BC), .LOOP(1'b0)) dut (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause),
        .beat_addr(got_addr[0]), .beat_notes(got_notes[0]),
        .spawn_valid(got_valid[0]), .spawn_lanes(got_lanes[0]), .spawn_ready(spawn_ready),
        .playing(got_play[0]), .done(got_done[0]), .overrun(got_over[0])
    );

    beatmap_player #(.BEAT_CYCLES(BC), .LOOP(1'b1)) dut_loop (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause),
        .beat_addr(got_addr[1]), .beat_notes(got_notes[1]),
        .spawn_valid(got_valid[1]), .spawn_lanes(got_lanes[1]), .spawn_ready(spawn_ready),
        .playing(got_play[1]), .done(got_done[1]), .overrun(got_over[1])
    );

    int tests_run = 0;
    int fails     = 0;

    bit       rdy_arr [N];
    bit       pse_arr [N];
    bit       stt_arr [N];
    bit       exp_valid [2][N];
    bit       exp_play  [2][N];
    bit       exp_done  [2][N];
    bit       exp_over  [2][N];
    bit [2:0] exp_addr  [2][N];
    bit [7:0] exp_lanes [2][N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each row owns BC un-paused edges starting at its fetch edge; a non-empty row is
    // offered on every edge after the fetch until accepted or the beat runs out.
    task automatic build_model(input int m);
        int  e, row, x, cnt, f, last;
        bit  over, acc, nz;
        for (int k = 0; k < N; k++) begin
            exp_valid[m][k] = 1'b0; exp_play[m][k] = 1'b0; exp_done[m][k] = 1'b0;
            exp_over[m][k]  = 1'b0; exp_addr[m][k] = 3'd0; exp_lanes[m][k] = 8'd0;
        end
        e = 1; row = 0; over = 1'b0;
        while (e < N) begin
            f   = e;
            nz  = (rom[row] != 8'd0);
            cnt = 0;
            x   = f;
            while (x < N) begin
                if (!pse_arr[x]) cnt++;
                if (cnt == BC) break;
                x++;
            end
            last = (x < N) ? x : N - 1;
            acc  = 1'b0;
            for (int k = f; k <= last; k++) begin
                exp_addr[m][k]  = 3'(row);
                exp_play[m][k]  = 1'b1;
                exp_over[m][k]  = over;
                exp_lanes[m][k] = rom[row];
                exp_valid[m][k] = nz && (k > f) && !acc;
                if (exp_valid[m][k] && rdy_arr[k]) acc = 1'b1;
            end
            if (nz && !acc) over = 1'b1;
            e = last + 1;
            if (row == 7 && m == 0) begin
                for (int k = e; k < N; k++) begin
                    exp_addr[m][k] = 3'd7;
                    exp_done[m][k] = 1'b1;
                    exp_over[m][k] = over;
                end
                e = N;
            end else begin
                row = (row + 1) % 8;
            end
        end
    endtask

    task automatic compare_edge(input int e);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("valid[%0d]@%0d", m, e), 32'(got_valid[m]), 32'(exp_valid[m][e]));
            check($sformatf("addr[%0d]@%0d", m, e), 32'(got_addr[m]), 32'(exp_addr[m][e]));
            check($sformatf("playing[%0d]@%0d", m, e), 32'(got_play[m]), 32'(exp_play[m][e]));
            check($sformatf("done[%0d]@%0d", m, e), 32'(got_done[m]), 32'(exp_done[m][e]));
            check($sformatf("overrun[%0d]@%0d", m, e), 32'(got_over[m]), 32'(exp_over[m][e]));
            if (exp_valid[m][e])
                check($sformatf("lanes[%0d]@%0d", m, e), 32'(got_lanes[m]), 32'(exp_lanes[m][e]));
        end
    endtask

    task automatic check_idle(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_addr[%0d]", tag, m), 32'(got_addr[m]), 32'd0);
            check($sformatf("%s_lanes[%0d]", tag, m), 32'(got_lanes[m]), 32'd0);
            check($sformatf("%s_valid[%0d]", tag, m), 32'(got_valid[m]), 32'd0);
            check($sformatf("%s_playing[%0d]", tag, m), 32'(got_play[m]), 32'd0);
            check($sformatf("%s_done[%0d]", tag, m), 32'(got_done[m]), 32'd0);
            check($sformatf("%s_overrun[%0d]", tag, m), 32'(got_over[m]), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0; start = 1'b0; pause = 1'b0; spawn_ready = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic set_default_rom();
        bit [7:0] rows [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};
        for (int r = 0; r < 8; r++) rom[r] = rows[r];
    endtask

    task automatic set_stim(input bit rdy);
        for (int k = 0; k < N; k++) begin
            rdy_arr[k] = rdy; pse_arr[k] = 1'b0; stt_arr[k] = 1'b0;
        end
    endtask

    // Edge 0 carries the start pulse; later starts only land where both players are busy.
    task automatic run_scenario();
        build_model(0);
        build_model(1);
        for (int e = 0; e < N; e++) begin
            @(negedge clock);
            if (e > 0) compare_edge(e);
            start       = (e == 0) || stt_arr[e];
            pause       = pse_arr[e];
            spawn_ready = rdy_arr[e];
        end
        @(negedge clock);
        start = 1'b0; pause = 1'b0; spawn_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pause = 1'b0; spawn_ready = 1'b0;
        set_default_rom();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        resetn = 1'b1;

        set_stim(1'b1);
        run_scenario();

        do_reset();
        set_stim(1'b0);
        run_scenario();

        do_reset();
        rom[2] = 8'h00;
        set_stim(1'b1);
        run_scenario();
        set_default_rom();

        do_reset();
        set_stim(1'b1);
        for (int k = 7; k <= 11; k++) pse_arr[k] = 1'b1;
        stt_arr[20] = 1'b1;
        run_scenario();

        // Reset while the first row is being offered, then replay from row 0.
        do_reset();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        check("pre_reset_valid", 32'(got_valid[0]), 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check_idle("mid_emit_reset");
        resetn = 1'b1;
        set_stim(1'b1);
        run_scenario();

        for (int run = 0; run < 6; run++) begin
            do_reset();
            for (int r = 0; r < 8; r++)
                rom[r] = ($urandom_range(99, 0) < 25) ? 8'h00 : 8'($urandom_range(255, 1));
            for (int k = 0; k < N; k++) begin
                rdy_arr[k] = ($urandom_range(99, 0) < 55);
                pse_arr[k] = ($urandom_range(99, 0) < 20);
                stt_arr[k] = 1'b0;
            end
            build_model(0);
            build_model(1);
            for (int k = 1; k < N; k++)
                stt_arr[k] = exp_play[0][k] && exp_play[1][k] && ($urandom_range(99, 0) < 10);
            run_scenario();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
